// File: rtl/mem_io_stage.sv
// Memory/IO stage: byte-lane stores to dmem/imem, memory-mapped UART and
// counters, and one-cycle-latency aligned/extended load return.
module mem_io_stage #(
    parameter int DMEM_AW = 12,
    parameter int IMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    input  logic               is_load,
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        store_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [3:0]         imem_we,
    output logic [31:0]        imem_din,
    input  logic               uart_tx_ready,
    output logic               uart_tx_valid,
    output logic [7:0]         uart_tx_data,
    input  logic               uart_rx_valid,
    output logic               uart_rx_ready,
    input  logic [7:0]         uart_rx_data,
    output logic [31:0]        load_data
);

    localparam logic [31:0] IO_CTRL = 32'h8000_0000;
    localparam logic [31:0] IO_RX   = 32'h8000_0004;
    localparam logic [31:0] IO_TX   = 32'h8000_0008;
    localparam logic [31:0] IO_CYC  = 32'h8000_0010;
    localparam logic [31:0] IO_INS  = 32'h8000_0014;
    localparam logic [31:0] IO_CLR  = 32'h8000_0018;

    logic        st_en, ld_en;
    logic        sel_dmem, sel_imem;
    logic [3:0]  base_mask, lane_we;
    logic [31:0] io_rdata;
    logic        tx_fire, rx_take, cnt_clr;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        ld_q, io_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] io_data_q;
    logic [31:0] word, shifted;

    assign st_en    = inst_valid & is_store;
    assign ld_en    = inst_valid & is_load;
    assign sel_dmem = !addr[31] & addr[28];
    assign sel_imem = !addr[31] & addr[29];

    assign dmem_addr = addr[DMEM_AW+1:2];
    assign imem_addr = addr[IMEM_AW+1:2];

    always_comb begin
        base_mask = 4'b1111;
        unique case (funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    // 4-bit shift drops lanes that fall past the word: misaligned h/w truncate
    assign lane_we  = base_mask << addr[1:0];
    assign dmem_din = store_data << {addr[1:0], 3'b000};
    assign imem_din = dmem_din;
    assign dmem_we  = (st_en & sel_dmem) ? lane_we : 4'b0000;
    assign imem_we  = (st_en & sel_imem) ? lane_we : 4'b0000;

    always_comb begin
        io_rdata = '0;
        case (addr)
            IO_CTRL: io_rdata = {30'b0, uart_rx_valid, uart_tx_ready};
            IO_RX:   io_rdata = {24'b0, uart_rx_data};
            IO_CYC:  io_rdata = cycle_cnt;
            IO_INS:  io_rdata = instr_cnt;
            default: io_rdata = '0;
        endcase
    end

    assign tx_fire = st_en & (addr == IO_TX) & uart_tx_ready;
    assign cnt_clr = st_en & (addr == IO_CLR);
    assign rx_take = ld_en & (addr == IO_RX);

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
            uart_rx_ready <= 1'b0;
            ld_q          <= 1'b0;
            io_q          <= 1'b0;
            off_q         <= '0;
            f3_q          <= '0;
            io_data_q     <= '0;
            cycle_cnt     <= '0;
            instr_cnt     <= '0;
        end else begin
            uart_tx_valid <= tx_fire;
            if (tx_fire) uart_tx_data <= store_data[7:0];
            uart_rx_ready <= rx_take;
            ld_q          <= ld_en;
            if (ld_en) begin
                io_q      <= addr[31];
                off_q     <= addr[1:0];
                f3_q      <= funct3;
                io_data_q <= io_rdata;
            end
            if (cnt_clr) begin
                cycle_cnt <= '0;
                instr_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                instr_cnt <= instr_cnt + 32'(inst_valid);
            end
        end
    end

    assign word    = io_q ? io_data_q : dmem_dout;
    assign shifted = word >> {off_q, 3'b000};

    always_comb begin
        load_data = '0;
        if (ld_q) begin
            unique case (f3_q)
                3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
                3'b100:  load_data = {24'b0, shifted[7:0]};
                3'b101:  load_data = {16'b0, shifted[15:0]};
                default: load_data = shifted;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_stage.sv
// Bench for mem_io_stage: directed vectors plus random dmem traffic
// checked against a byte-addressed reference memory.
module tb_mem_io_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [11:0] dmem_addr, imem_addr;
    logic [3:0]  dmem_we, imem_we;
    logic [31:0] dmem_din, imem_din, dmem_dout, load_data;
    logic        uart_tx_ready, uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_rx_valid, uart_rx_ready;
    logic [7:0]  uart_rx_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bram [0:4095] = '{default: '0};
    logic [7:0]  ref_mem [0:255] = '{default: '0};

    mem_io_stage dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
        .dmem_dout(dmem_dout), .imem_addr(imem_addr), .imem_we(imem_we),
        .imem_din(imem_din), .uart_tx_ready(uart_tx_ready),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .uart_rx_data(uart_rx_data), .load_data(load_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM environment
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dmem_we[i]) bram[dmem_addr][8*i +: 8] <= dmem_din[8*i +: 8];
        dmem_dout <= bram[dmem_addr];
    end

    task automatic drive(input logic iv, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        inst_valid = iv; is_load = ld; is_store = st;
        funct3 = f3; addr = a; store_data = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_we(input logic [2:0] f3,
                                          input logic [31:0] a);
        logic [3:0] m;
        int off;
        m = '0;
        off = int'(a[1:0]);
        for (int k = 0; k < acc_size(f3); k++)
            if (off + k < 4) m[off+k] = 1'b1;
        return m;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
        int base, off;
        base = int'(a[7:0]) & 'hFC;
        off = int'(a[1:0]);
        for (int k = 0; k < acc_size(f3); k++)
            if (off + k < 4) ref_mem[base+off+k] = d[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] w, s;
        int base;
        base = int'(a[7:0]) & 'hFC;
        w = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        s = w >> (8 * int'(a[1:0]));
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        inst_valid = 0; is_load = 0; is_store = 0;
        funct3 = 0; addr = 0; store_data = 0;
        uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
        repeat (3) tick();
        n_cmp++;
        if (uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_uart: tx_valid=%b rx_ready=%b want 0/0",
                     uart_tx_valid, uart_rx_ready);
        end
        n_cmp++;
        if (uart_tx_data !== 8'h00 || load_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: tx_data=%h load_data=%h want 0/0",
                     uart_tx_data, load_data);
        end
        @(negedge clk);
        rst = 1'b0;
        uart_tx_ready = 1'b1;
        drive(1, 1, 0, 3'b010, 32'h8000_0000, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'h1) begin
            n_bad++;
            $display("FAIL ctrl_read: got %h want %h", load_data, 32'h1);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (load_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_midload: got %h want 0", load_data);
        end
        @(negedge clk);
        rst = 1'b0;
        uart_tx_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_store_lanes;
        drive(1, 0, 1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
        n_cmp++;
        if (dmem_we !== 4'b1111 || dmem_addr !== 12'd1 ||
            dmem_din !== 32'hDEAD_BEEF || imem_we !== 4'b0000) begin
            n_bad++;
            $display("FAIL sw_dmem: we=%b addr=%h din=%h iwe=%b want 1111/1/deadbeef/0000",
                     dmem_we, dmem_addr, dmem_din, imem_we);
        end
        tick();
        ref_store(3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
        drive(1, 0, 1, 3'b000, 32'h1000_0003, 32'h0000_00A5);
        n_cmp++;
        if (dmem_we !== 4'b1000 || dmem_din !== 32'hA500_0000) begin
            n_bad++;
            $display("FAIL sb_lane3: we=%b din=%h want 1000/a5000000",
                     dmem_we, dmem_din);
        end
        tick();
        ref_store(3'b000, 32'h1000_0003, 32'h0000_00A5);
        drive(1, 1, 0, 3'b000, 32'h1000_0003, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'hFFFF_FFA5) begin
            n_bad++;
            $display("FAIL lb_sext: got %h want ffffffa5", load_data);
        end
        drive(1, 1, 0, 3'b100, 32'h1000_0003, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'h0000_00A5) begin
            n_bad++;
            $display("FAIL lbu_zext: got %h want 000000a5", load_data);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'h0) begin
            n_bad++;
            $display("FAIL bubble_after_load: got %h want 0", load_data);
        end
        drive(1, 0, 1, 3'b001, 32'h1000_0002, 32'hCAFE_1234);
        n_cmp++;
        if (dmem_we !== 4'b1100 || dmem_din !== 32'h1234_0000) begin
            n_bad++;
            $display("FAIL sh_lane2: we=%b din=%h want 1100/12340000",
                     dmem_we, dmem_din);
        end
        tick();
        ref_store(3'b001, 32'h1000_0002, 32'hCAFE_1234);
        n_cmp++;
        if (load_data !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_after_store: got %h want 0", load_data);
        end
        drive(1, 0, 1, 3'b010, 32'h3000_0000, 32'h0BAD_F00D);
        n_cmp++;
        if (dmem_we !== 4'b1111 || imem_we !== 4'b1111 ||
            imem_din !== 32'h0BAD_F00D) begin
            n_bad++;
            $display("FAIL sw_both: dwe=%b iwe=%b idin=%h want 1111/1111/0badf00d",
                     dmem_we, imem_we, imem_din);
        end
        tick();
        ref_store(3'b010, 32'h3000_0000, 32'h0BAD_F00D);
        drive(0, 0, 1, 3'b010, 32'h3000_0000, 32'h1111_1111);
        n_cmp++;
        if (dmem_we !== 4'b0000 || imem_we !== 4'b0000) begin
            n_bad++;
            $display("FAIL sw_bubble: dwe=%b iwe=%b want 0000/0000",
                     dmem_we, imem_we);
        end
        tick();
        drive(1, 0, 1, 3'b010, 32'h2000_0008, 32'h5);
        n_cmp++;
        if (imem_we !== 4'b1111 || dmem_we !== 4'b0000 ||
            imem_addr !== 12'd2) begin
            n_bad++;
            $display("FAIL sw_imem: iwe=%b dwe=%b iaddr=%h want 1111/0000/2",
                     imem_we, dmem_we, imem_addr);
        end
        tick();
    endtask

    task automatic test_uart_tx;
        uart_tx_ready = 1'b1;
        drive(1, 0, 1, 3'b010, 32'h8000_0008, 32'h0000_0041);
        tick();
        n_cmp++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            n_bad++;
            $display("FAIL tx_pulse: valid=%b data=%h want 1/41",
                     uart_tx_valid, uart_tx_data);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++;
        if (uart_tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_one_cycle: valid=%b want 0", uart_tx_valid);
        end
        uart_tx_ready = 1'b0;
        drive(1, 0, 1, 3'b010, 32'h8000_0008, 32'h0000_0055);
        tick();
        n_cmp++;
        if (uart_tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_not_ready: valid=%b want 0", uart_tx_valid);
        end
        uart_tx_ready = 1'b1;
        drive(0, 0, 1, 3'b010, 32'h8000_0008, 32'h0000_0066);
        tick();
        n_cmp++;
        if (uart_tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_bubble: valid=%b want 0", uart_tx_valid);
        end
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_uart_rx;
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h7F;
        drive(1, 1, 0, 3'b010, 32'h8000_0004, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'h7F || uart_rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rx_read: data=%h ready=%b want 7f/1",
                     load_data, uart_rx_ready);
        end
        drive(1, 1, 0, 3'b010, 32'h8000_0000, 0);
        tick();
        n_cmp++;
        if (uart_rx_ready !== 1'b0 || load_data !== 32'h2) begin
            n_bad++;
            $display("FAIL rx_ctrl: ready=%b data=%h want 0/2",
                     uart_rx_ready, load_data);
        end
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'h80;
        drive(1, 1, 0, 3'b000, 32'h8000_0004, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'hFFFF_FF80 || uart_rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rx_stale_lb: data=%h ready=%b want ffffff80/1",
                     load_data, uart_rx_ready);
        end
        drive(1, 1, 0, 3'b010, 32'h8000_000C, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'h0 || uart_rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL io_unmapped: data=%h ready=%b want 0/0",
                     load_data, uart_rx_ready);
        end
    endtask

    task automatic test_counters;
        int n, v;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            rst = 1'b1;
            inst_valid = 0; is_load = 0; is_store = 0;
            tick();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                rst = 1'b0;
                inst_valid = (i < 6);
            end
            drive(1, 1, 0, 3'b010,
                  pass == 0 ? 32'h8000_0010 : 32'h8000_0014, 0);
            tick();
            n_cmp++;
            if (load_data !== (pass == 0 ? 32'd10 : 32'd6)) begin
                n_bad++;
                $display("FAIL cnt_after_reset%0d: got %0d want %0d",
                         pass, load_data, pass == 0 ? 10 : 6);
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            drive(1, 0, 1, 3'b010, 32'h8000_0018, 0);
            tick();
            drive(1, 1, 0, 3'b010,
                  pass == 0 ? 32'h8000_0010 : 32'h8000_0014, 0);
            tick();
            n_cmp++;
            if (load_data !== 32'd0) begin
                n_bad++;
                $display("FAIL cnt_clear%0d: got %0d want 0", pass, load_data);
            end
        end
        drive(1, 0, 1, 3'b010, 32'h8000_0018, 0);
        tick();
        n = $urandom_range(3, 20);
        v = 0;
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 1) == 1, 0, 0, 0, 0, 0);
            if (inst_valid) v++;
            tick();
        end
        drive(1, 1, 0, 3'b010, 32'h8000_0014, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'(v)) begin
            n_bad++;
            $display("FAIL instr_cnt_rand: got %0d want %0d", load_data, v);
        end
        drive(1, 1, 0, 3'b010, 32'h8000_0010, 0);
        tick();
        n_cmp++;
        if (load_data !== 32'(n + 1)) begin
            n_bad++;
            $display("FAIL cycle_cnt_rand: got %0d want %0d", load_data, n + 1);
        end
    endtask

    task automatic test_random_dmem;
        logic        iv, ld, st;
        logic [2:0]  f3;
        logic [31:0] a, d;
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int op;
        for (int i = 0; i < 300; i++) begin
            iv = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 2);
            ld = (op == 1);
            st = (op == 2);
            f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a = 32'h1000_0000 | 32'($urandom_range(0, 255));
            d = $urandom;
            drive(iv, ld, st, f3, a, d);
            n_cmp++;
            if (dmem_we !== ((iv && st) ? exp_we(f3, a) : 4'b0000)) begin
                n_bad++;
                $display("FAIL rand_we[%0d]: got %b want %b", i, dmem_we,
                         (iv && st) ? exp_we(f3, a) : 4'b0000);
            end
            if (iv && st) begin
                n_cmp++;
                if (dmem_din !== (d << (8 * int'(a[1:0])))) begin
                    n_bad++;
                    $display("FAIL rand_din[%0d]: got %h want %h", i, dmem_din,
                             d << (8 * int'(a[1:0])));
                end
            end
            tick();
            if (iv && st) ref_store(f3, a, d);
            n_cmp++;
            if (load_data !== ((iv && ld) ? ref_load(f3, a) : 32'h0)) begin
                n_bad++;
                $display("FAIL rand_load[%0d]: got %h want %h", i, load_data,
                         (iv && ld) ? ref_load(f3, a) : 32'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_uart_tx();
        test_uart_rx();
        test_counters();
        test_random_dmem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
